stage_4: RTL and testbench
==========================

# stage_4

Memory-access stage of the five-stage RV32I pipeline. It sits between the execute stage and the write-back stage. It takes the execute-stage bundle (ALU result/address, store data, destination register, opcode, func_3, op_type) under a valid/ready handshake. For loads and stores it runs a multi-cycle request/acknowledge transaction on the data-memory port, with byte-lane steering and load sign/zero extension. Non-memory results pass through a single output register to write-back.

## Interface
- `TIMEOUT`, 255: maximum cycles waiting for `mem_ack` before aborting; range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `i_valid`  in  1  execute bundle valid.
- `o_ready`  out  1  stage can accept a bundle this cycle.
- `i_alu_out`  in  32  ALU result, or effective address when `i_op_type`=1.
- `i_rs_2`  in  32  store data.
- `i_rd_num`  in  5  destination register.
- `i_opcode`  in  7  RV32I opcode (LOAD=0000011, STORE=0100011).
- `i_func_3`  in  3  width/sign selector.
- `i_op_type`  in  1  1 = memory op, 0 = ALU/jump/LUI/AUIPC.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address (`{addr[31:2],2'b00}`).
- `mem_wdata`  out  32  write data, lane-replicated.
- `mem_be`  out  4  byte enables.
- `mem_ack`  in  1  one-cycle completion pulse.
- `mem_rdata`  in  32  read word, valid with `mem_ack`.
- `o_valid`  out  1  write-back bundle valid.
- `i_ready`  in  1  write-back accepts the bundle.
- `rd_num`  out  5  destination register.
- `wb_data`  out  32  write-back value.
- `wb_en`  out  1  register-file write enable.
- `err`  out  1  fault flag for the bundle.
- `err_cause`  out  2  0 none, 1 misaligned, 2 illegal func_3, 3 timeout.

## Operation
- FSM states:
  - IDLE → ACCESS: accept memory op, legal and aligned.
  - ACCESS → IDLE: `mem_ack`, or timeout, with the output register loaded.
- Accept condition: `i_valid && o_ready`.
- `o_ready` = `!rst && state==IDLE && (!o_valid || i_ready)`.
- Non-memory op (`i_op_type`=0):
  - Output loads `wb_data=i_alu_out` and `rd_num` on the accept edge.
  - `wb_en` = (`i_rd_num`!=0).
  - `err`=0.
- Loads, func_3 decode: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; 3/6/7 are illegal.
- Stores, func_3 decode: 0 SB, 1 SH, 2 SW; 3..7 are illegal.
- Alignment: halfword needs `a[0]`=0; word needs `a[1:0]`=0, where `a` = `i_alu_out`.
- An illegal or misaligned op issues no memory request:
  - Output loads next edge with `err`=1, the matching cause, `wb_en`=0, `wb_data`=0.
  - Illegal func_3 takes priority over misalignment.
- Store lanes:
  - SB: `mem_be`=1<<a[1:0], `mem_wdata`={4{rs2[7:0]}}.
  - SH: `mem_be`=0011 if a[1]=0, else 1100; `mem_wdata`={2{rs2[15:0]}}.
  - SW: `mem_be`=1111, `mem_wdata`=rs2.
- Loads:
  - `mem_be` follows the same lane rule; `mem_we`=0.
  - Selected byte/halfword comes from `mem_rdata` at lane `a[1:0]`.
  - Sign-extended for LB/LH, zero-extended for LBU/LHU.
- Load write-back: `wb_en` = (`rd`!=0); stores always give `wb_en`=0.
- Address, lanes and write data are registered at accept and held stable throughout ACCESS.
- Timeout counter:
  - Cleared at accept, increments each ACCESS cycle without ack.
  - Reaching `TIMEOUT` drops `mem_req` and loads the output with `err_cause`=3, `wb_en`=0.
- `mem_ack` outside ACCESS is ignored.

## Timing
- Reset values: state IDLE; `o_valid`, `mem_req`, `mem_we`, `wb_en`, `err` all 0; `mem_addr`, `mem_wdata`, `mem_be`, `rd_num`, `wb_data`, `err_cause` all 0.
- Non-memory and faulting ops: 1-cycle latency; `o_valid` rises on the edge after accept.
- Memory ops:
  - Accept at edge N; `mem_req`=1 from N+1.
  - `mem_ack` sampled at edge M drops `mem_req` and sets `o_valid` at that same edge M.
  - Zero-wait memory (ack in first request cycle) gives 2-cycle latency.
- `o_valid` and its bundle hold unchanged until `o_valid && i_ready`.
- The output clears on a transfer unless a new bundle loads in the same edge.
- Back-to-back pass-through sustains one bundle per cycle when `i_ready`=1.
- No new bundle is accepted while in ACCESS.
- An ACCESS completion while the output is still full cannot occur, because accept requires the output to drain.
- Reset mid-ACCESS: `mem_req` is 0 on the next edge, the transaction is abandoned, and a late ack is ignored.

## Test plan
- ADDI pass-through: `i_alu_out`=0x1234, rd=5, `i_ready`=1 → `o_valid` one cycle later, `wb_data`=0x1234, `wb_en`=1. With rd=0 → `wb_en`=0.
- LB from `a`=0x103, `mem_rdata`=0x80AABBCC, ack after 3 cycles → `mem_addr`=0x100, `mem_be`=1000, `wb_data`=0xFFFFFF80. LBU on the same access → 0x00000080.
- SH to 0x202, rs2=0xDEADBEEF → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xBEEFBEEF, `wb_en`=0.
- LW at 0x101 → no `mem_req`, `err`=1, `err_cause`=1. Load with func_3=3 → `err_cause`=2.
- `TIMEOUT`=4, LW with no ack → `mem_req` high 4 cycles then low, `err_cause`=3. An ack arriving afterwards has no effect.
- Back-pressure: `i_ready`=0 for 5 cycles with a completed load → bundle stable, `o_ready`=0. Then `i_ready`=1 → transfer, and the next bundle is accepted that edge. Also assert `rst` during ACCESS → all outputs 0 on the next edge.

Source files
------------

// File: rtl/stage_4.sv
// stage_4: RV32I memory-access stage.
// Runs load/store req/ack transactions and registers the write-back bundle.
module stage_4 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic        i_op_type,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [4:0]  rd_num,
  output logic [31:0] wb_data,
  output logic        wb_en,
  output logic        err,
  output logic [1:0]  err_cause
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        en;
    logic        err;
    logic [1:0]  cause;
  } wb_t;

  state_t state, state_n;

  logic        accept, xfer, fault;
  logic        go_mem, done, tmo;
  logic        is_ld, is_st;
  logic        bad_f3, misal;
  logic [1:0]  a_lo, sz;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [7:0]  cnt;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] sh, ld_val;
  logic        ld_out;
  wb_t         wb_q, wb_n;

  assign o_ready = !rst && state == IDLE
                && (!o_valid || i_ready);
  assign accept  = i_valid && o_ready;
  assign xfer    = o_valid && i_ready;
  assign fault   = bad_f3 || misal;
  assign go_mem  = accept && i_op_type && !fault;
  assign tmo     = cnt == TMO_LAST;
  assign done    = state == ACCESS
                && (mem_ack || tmo);

  // Decode width, legality and lanes from the incoming bundle.
  always_comb begin
    a_lo  = i_alu_out[1:0];
    sz    = i_func_3[1:0];
    is_ld = i_opcode == OP_LOAD;
    is_st = i_opcode == OP_STORE;
    unique case (1'b1)
      is_ld:   bad_f3 = sz == 2'd3
                     || i_func_3[2:1] == 2'b11;
      is_st:   bad_f3 = i_func_3[2]
                     || sz == 2'd3;
      default: bad_f3 = 1'b1;
    endcase
    case (sz)
      2'd1:    misal = a_lo[0];
      2'd2:    misal = a_lo != 2'd0;
      default: misal = 1'b0;
    endcase
    case (sz)
      2'd0: begin
        be_n = 4'b0001 << a_lo;
        wd_n = {4{i_rs_2[7:0]}};
      end
      2'd1: begin
        be_n = a_lo[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{i_rs_2[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = i_rs_2;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (go_mem) state_n = ACCESS;
      ACCESS:  if (done)   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    mem_req = state == ACCESS;
  end

  // Request fields stay frozen for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      mem_we    <= 1'b0;
      lane_q    <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      cnt       <= '0;
    end else if (go_mem) begin
      mem_addr  <= {i_alu_out[31:2], 2'b00};
      mem_wdata <= wd_n;
      mem_be    <= be_n;
      mem_we    <= is_st;
      lane_q    <= a_lo;
      f3_q      <= i_func_3;
      rd_q      <= i_rd_num;
      cnt       <= '0;
    end else if (state == ACCESS && !done) begin
      cnt       <= cnt + 8'd1;
    end
  end

  always_comb begin
    sh = mem_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'd0:    ld_val = {{24{sh[7]}}, sh[7:0]};
      3'd1:    ld_val = {{16{sh[15]}}, sh[15:0]};
      3'd4:    ld_val = {24'd0, sh[7:0]};
      3'd5:    ld_val = {16'd0, sh[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    wb_n   = '0;
    ld_out = 1'b1;
    unique case (1'b1)
      accept && !i_op_type: begin
        wb_n.rd   = i_rd_num;
        wb_n.data = i_alu_out;
        wb_n.en   = i_rd_num != 5'd0;
      end
      accept && i_op_type && fault: begin
        wb_n.rd    = i_rd_num;
        wb_n.err   = 1'b1;
        wb_n.cause = bad_f3 ? 2'd2 : 2'd1;
      end
      done && mem_ack: begin
        wb_n.rd   = rd_q;
        wb_n.data = mem_we ? 32'd0 : ld_val;
        wb_n.en   = !mem_we && rd_q != 5'd0;
      end
      done && !mem_ack: begin
        wb_n.rd    = rd_q;
        wb_n.err   = 1'b1;
        wb_n.cause = 2'd3;
      end
      default: ld_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      wb_q    <= '0;
    end else if (ld_out) begin
      o_valid <= 1'b1;
      wb_q    <= wb_n;
    end else if (xfer) begin
      o_valid <= 1'b0;
      wb_q    <= '0;
    end
  end

  assign rd_num    = wb_q.rd;
  assign wb_data   = wb_q.data;
  assign wb_en     = wb_q.en;
  assign err       = wb_q.err;
  assign err_cause = wb_q.cause;

endmodule

// File: tb/tb_stage_4.sv
// tb_stage_4: directed and random checks of stage_4
// against a byte-level reference model.
module tb_stage_4;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_alu_out;
  logic [31:0] i_rs_2;
  logic [4:0]  i_rd_num;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func_3;
  logic        i_op_type;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [4:0]  rd_num;
  logic [31:0] wb_data;
  logic        wb_en;
  logic        err;
  logic [1:0]  err_cause;

  always #5 clk = ~clk;

  stage_4 #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_alu_out (i_alu_out),
    .i_rs_2    (i_rs_2),
    .i_rd_num  (i_rd_num),
    .i_opcode  (i_opcode),
    .i_func_3  (i_func_3),
    .i_op_type (i_op_type),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .rd_num    (rd_num),
    .wb_data   (wb_data),
    .wb_en     (wb_en),
    .err       (err),
    .err_cause (err_cause)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  rd;
    logic [31:0] wb;
    logic        wben;
    logic        err;
    logic [1:0]  cause;
  } exp_t;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %08h want %08h",
             tag, obs, exp);
    end
  endtask

  // Expected result from the ISA rules, byte by byte.
  function automatic exp_t model(
      input logic [6:0]  op,
      input logic [2:0]  f3,
      input bit          mt,
      input logic [31:0] a,
      input logic [31:0] rs2,
      input logic [4:0]  rd,
      input logic [31:0] rdata,
      input bit          tmo);
    exp_t   e;
    int     size;
    int     off;
    longint v;
    bit     ld, st, legal;
    e = '0;
    e.rd = rd;
    if (!mt) begin
      e.wb   = a;
      e.wben = rd != 0;
      return e;
    end
    ld = op == 7'h03;
    st = op == 7'h23;
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 0;
    endcase
    legal = (ld && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
         || (st && f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal) begin
      e.err = 1'b1;
      e.cause = 2'd2;
      return e;
    end
    off = int'(a % 4);
    if (off % size != 0) begin
      e.err = 1'b1;
      e.cause = 2'd1;
      return e;
    end
    e.req  = 1'b1;
    e.we   = st;
    e.addr = a - 32'(off);
    for (int k = 0; k < size; k++) e.be[off+k] = 1'b1;
    for (int k = 0; k < 4; k++)
      e.wdata[8*k +: 8] = rs2[8*(k % size) +: 8];
    if (tmo) begin
      e.err = 1'b1;
      e.cause = 2'd3;
      return e;
    end
    if (st) return e;
    v = longint'(rdata) >> (8 * off);
    if (size < 4) begin
      v = v % (64'sd1 << (8 * size));
      if (f3 < 3'd4 && v >= (64'sd1 << (8 * size - 1)))
        v = v - (64'sd1 << (8 * size));
    end
    e.wb   = v[31:0];
    e.wben = rd != 0;
    return e;
  endfunction

  task automatic run_op(input logic [6:0]  op,
                        input logic [2:0]  f3,
                        input bit          mt,
                        input logic [31:0] a,
                        input logic [31:0] rs2,
                        input logic [4:0]  rd,
                        input int          waits,
                        input bit          ack,
                        input logic [31:0] rdata,
                        input string       tag);
    exp_t e;
    int   n;
    e = model(op, f3, mt, a, rs2, rd, rdata, !ack);
    n = 0;
    while (!o_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "/o_ready"}, 32'(o_ready), 32'd1);
    i_valid   = 1'b1;
    i_opcode  = op;
    i_func_3  = f3;
    i_op_type = mt;
    i_alu_out = a;
    i_rs_2    = rs2;
    i_rd_num  = rd;
    @(posedge clk); #1;
    i_valid   = 1'b0;
    if (e.req) begin
      chk({tag, "/req"},   32'(mem_req), 32'd1);
      chk({tag, "/addr"},  mem_addr, e.addr);
      chk({tag, "/be"},    32'(mem_be), 32'(e.be));
      chk({tag, "/wdata"}, mem_wdata, e.wdata);
      chk({tag, "/we"},    32'(mem_we), 32'(e.we));
      chk({tag, "/early"}, 32'(o_valid), 32'd0);
      if (ack) begin
        repeat (waits) begin
          @(posedge clk); #1;
        end
        chk({tag, "/hold"}, 32'(mem_req), 32'd1);
        chk({tag, "/haddr"}, mem_addr, e.addr);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end else begin
        n = 0;
        while (mem_req && n < 300) begin
          n++;
          @(posedge clk); #1;
        end
        chk({tag, "/tmo_len"}, 32'(n), 32'(TMO));
      end
    end
    chk({tag, "/o_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "/req_off"}, 32'(mem_req), 32'd0);
    chk({tag, "/wb_data"}, wb_data, e.wb);
    chk({tag, "/wb_en"},   32'(wb_en), 32'(e.wben));
    chk({tag, "/err"},     32'(err), 32'(e.err));
    chk({tag, "/cause"},   32'(err_cause), 32'(e.cause));
    if (!e.err) chk({tag, "/rd"}, 32'(rd_num), 32'(e.rd));
  endtask

  exp_t        ebp;
  int          kind;
  logic [6:0]  r_op;
  logic [2:0]  r_f3;
  logic [31:0] r_a;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    i_alu_out = '0;
    i_rs_2 = '0;
    i_rd_num = '0;
    i_opcode = '0;
    i_func_3 = '0;
    i_op_type = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/o_valid", 32'(o_valid), 32'd0);
    chk("rst/req", 32'(mem_req), 32'd0);
    chk("rst/we", 32'(mem_we), 32'd0);
    chk("rst/wb_en", 32'(wb_en), 32'd0);
    chk("rst/err", 32'(err), 32'd0);
    chk("rst/addr", mem_addr, 32'd0);
    chk("rst/wdata", mem_wdata, 32'd0);
    chk("rst/be", 32'(mem_be), 32'd0);
    chk("rst/rd", 32'(rd_num), 32'd0);
    chk("rst/wb_data", wb_data, 32'd0);
    chk("rst/cause", 32'(err_cause), 32'd0);
    chk("rst/o_ready", 32'(o_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(7'h13, 3'd0, 1'b0, 32'h1234, 32'd0,
           5'd5, 0, 1'b1, 32'd0, "addi");
    run_op(7'h13, 3'd0, 1'b0, 32'h5678, 32'd0,
           5'd0, 0, 1'b1, 32'd0, "addi_x0");
    run_op(7'h03, 3'd0, 1'b1, 32'h103, 32'd0,
           5'd3, 3, 1'b1, 32'h80AABBCC, "lb");
    run_op(7'h03, 3'd4, 1'b1, 32'h103, 32'd0,
           5'd3, 3, 1'b1, 32'h80AABBCC, "lbu");
    run_op(7'h23, 3'd1, 1'b1, 32'h202, 32'hDEADBEEF,
           5'd0, 1, 1'b1, 32'd0, "sh");
    run_op(7'h03, 3'd2, 1'b1, 32'h101, 32'd0,
           5'd4, 0, 1'b1, 32'd0, "lw_misal");
    run_op(7'h03, 3'd3, 1'b1, 32'h100, 32'd0,
           5'd4, 0, 1'b1, 32'd0, "ld_f3");
    run_op(7'h03, 3'd2, 1'b1, 32'h400, 32'd0,
           5'd9, 0, 1'b0, 32'd0, "lw_tmo");
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack/o_valid", 32'(o_valid), 32'd0);
    chk("late_ack/req", 32'(mem_req), 32'd0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      r_op = kind == 0 ? 7'h13
           : kind == 1 ? 7'h03 : 7'h23;
      r_f3 = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
      run_op(r_op, r_f3, kind != 0, r_a, $urandom,
             5'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 7) != 0, $urandom, "rnd");
    end

    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    ebp = model(7'h03, 3'd1, 1'b1, 32'h302, 32'd0,
                5'd6, 32'h8001_7FFF, 1'b0);
    run_op(7'h03, 3'd1, 1'b1, 32'h302, 32'd0,
           5'd6, 1, 1'b1, 32'h8001_7FFF, "bp_lh");
    i_valid   = 1'b1;
    i_op_type = 1'b0;
    i_opcode  = 7'h13;
    i_alu_out = 32'h55;
    i_rd_num  = 5'd7;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp/o_valid", 32'(o_valid), 32'd1);
      chk("bp/wb_data", wb_data, ebp.wb);
      chk("bp/o_ready", 32'(o_ready), 32'd0);
    end
    i_ready = 1'b1;
    #1;
    chk("bp/release_rdy", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("bp/next_valid", 32'(o_valid), 32'd1);
    chk("bp/next_data", wb_data, 32'h55);
    chk("bp/next_rd", 32'(rd_num), 32'd7);

    @(posedge clk); #1;
    i_valid   = 1'b1;
    i_op_type = 1'b1;
    i_opcode  = 7'h03;
    i_func_3  = 3'd2;
    i_alu_out = 32'h40;
    i_rd_num  = 5'd2;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("rstacc/req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstacc/req0", 32'(mem_req), 32'd0);
    chk("rstacc/o_valid", 32'(o_valid), 32'd0);
    chk("rstacc/addr", mem_addr, 32'd0);
    chk("rstacc/be", 32'(mem_be), 32'd0);
    chk("rstacc/wdata", mem_wdata, 32'd0);
    chk("rstacc/we", 32'(mem_we), 32'd0);
    chk("rstacc/wb_data", wb_data, 32'd0);
    chk("rstacc/o_ready", 32'(o_ready), 32'd0);
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rstacc/late_valid", 32'(o_valid), 32'd0);
    chk("rstacc/late_req", 32'(mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
